fir_decimator_fifo: RTL and testbench
=====================================

// Module: fir_decimator_fifo
// PURPOSE
//  Downstream stage of FIR_Filter: takes the filter's per-clock data_out stream as data_in.
//  Discards the filter warm-up samples and keeps every DECIM-th sample after that.
//  Buffers kept samples in a small first-word-fall-through FIFO with a valid/ready output.
//  Flags any sample lost to a full FIFO with a sticky overflow bit.
// PARAMETERS
//  N       8  sample width, equal to FIR_Filter N
//  WARMUP  5  accepted samples discarded after reset (filter pipeline fill); 0 allowed
//  DECIM   4  decimation ratio, >=1; 1 = keep every post-warm-up sample
//  DEPTH   4  FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1                    rising-edge clock, shared with FIR_Filter
//  reset      in   1                    asynchronous, active-low reset
//  en         in   1                    data_in is a new sample this cycle
//  data_in    in   N                    FIR_Filter data_out
//  out_data   out  N                    FIFO head (FWFT)
//  out_valid  out  1                    FIFO non-empty
//  out_ready  in   1                    consumer accepts head this cycle
//  fifo_count out  $clog2(DEPTH+1)      stored entries, 0..DEPTH
//  overflow   out  1                    sticky: a kept sample was dropped
//  clear_ovf  in   1                    synchronous clear of overflow
// BEHAVIOUR
//  Reset (reset=0, async, no clock needed): warm-up count=0, decim phase=0, rd/wr ptr=0,
//   storage=0, fifo_count=0, out_valid=0, out_data=0, overflow=0. Held while reset=0.
//  Accept: sample accepted on rising edge with en=1. en=0: all counters and FIFO push hold.
//  Warm-up: first WARMUP accepted samples dropped; saturating counter, no overflow effect.
//  Decimation: after warm-up, phase counts 0..DECIM-1, wraps to 0. Keep sample when phase=0.
//   Kept indexes (0-based, accepted samples): WARMUP, WARMUP+DECIM, WARMUP+2*DECIM, ...
//  Pop: out_valid & out_ready at the edge removes head; rd_ptr wraps mod DEPTH.
//  Push: kept sample written at wr_ptr at the same edge; wr_ptr wraps mod DEPTH.
//  Full (count=DEPTH) and kept sample:
//   with pop same edge: push accepted, count stays DEPTH, order preserved;
//   without pop: sample dropped, FIFO unchanged, overflow<=1.
//  Empty (count=0) and kept sample: pop ignored; sample visible on out_data, out_valid=1 after that edge.
//   Latency is 1 clock from sampling edge to out_valid.
//  out_valid = (fifo_count!=0). out_data = storage[rd_ptr]; holds stale value when empty.
//  fifo_count: +1 push only, -1 pop only, unchanged for both or neither.
//  clear_ovf=1 clears overflow at the edge, except a drop event in the same edge wins (overflow=1).
//  No arithmetic on data; samples pass bit-exact.
// TESTING
//  T1 reset, then en=1, out_ready=1, data_in ramp 0x01,0x02,...; WARMUP=5, DECIM=4
//     -> out_data 0x06,0x0A,0x0E,0x12; first out_valid after edge sampling 0x06.
//     -> each out_valid lasts 1 cycle; fifo_count never exceeds 1.
//  T2 as T1 with out_ready=0 -> fifo_count 1,2,3,4, overflow=0.
//     -> 5th kept sample (0x16) drops, overflow=1; then out_ready=1 drains 0x06,0x0A,0x0E,0x12.
//  T3 FIFO full, out_ready=1 on the edge where 0x16 is kept -> count stays 4, overflow=0.
//     -> drain order 0x0A,0x0E,0x12,0x16.
//  T4 T1 stimulus with en low every other cycle -> identical output value sequence.
//     -> phase and warm-up counters advance only on en=1.
//  T5 reset pulsed low mid-clock after 3 outputs -> out_valid, fifo_count, overflow go 0 without an edge.
//     -> after release, next 5 accepted samples discarded again.
//  T6 overflow set, clear_ovf=1 on an edge with a new drop -> overflow stays 1.
//     -> clear_ovf=1 on the next edge, no drop -> overflow=0.

Source files
------------

// File: rtl/fir_decimator_fifo.sv
// rtl/fir_decimator_fifo.sv - FIR output warm-up discard, decimation and FWFT output FIFO
// Drops pipeline-fill samples, keeps every DECIM-th sample, buffers it with a sticky overflow flag.
module fir_decimator_fifo #(
   parameter int N      = 8,
   parameter int WARMUP = 5,
   parameter int DECIM  = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [N-1:0]               data_in,
   output logic [N-1:0]               out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       overflow,
   input  logic                       clear_ovf
);

   localparam int WW = $clog2(WARMUP + 2);
   localparam int PW = $clog2(DECIM + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [WW-1:0] WARMUP_C   = WW'(WARMUP);
   localparam logic [PW-1:0] DECIM_LAST = PW'(DECIM - 1);
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

   logic [WW-1:0] warm_cnt;
   logic [PW-1:0] phase;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [N-1:0]  storage [DEPTH];

   logic warm_done;
   logic keep;
   logic full;
   logic pop;
   logic push;
   logic drop;

   assign warm_done = (warm_cnt == WARMUP_C);
   assign keep      = en && warm_done && (phase == '0);
   assign full      = (fifo_count == DEPTH_C);
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts a kept sample when the head leaves on the same edge.
   assign push      = keep && (!full || pop);
   assign drop      = keep && full && !pop;
   assign out_data  = storage[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         warm_cnt <= '0;
         phase    <= '0;
      end else if (en) begin
         if (!warm_done) begin
            warm_cnt <= warm_cnt + WW'(1);
         end else if (phase == DECIM_LAST) begin
            phase <= '0;
         end else begin
            phase <= phase + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else begin
         if (push) begin
            storage[wr_ptr] <= data_in;
            wr_ptr          <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // A drop on the same edge as clear_ovf leaves the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_decimator_fifo.sv
// tb/tb_fir_decimator_fifo.sv - scoreboard bench for fir_decimator_fifo
module tb_fir_decimator_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       out_ready = 1'b0;
   logic       clear_ovf = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic [2:0] fifo_count;
   logic       overflow;

   int         checks = 0;
   int         errors = 0;
   int         acc = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   fir_decimator_fifo #(.N(8), .WARMUP(5), .DECIM(4), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .data_in    (data_in),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .clear_ovf  (clear_ovf)
   );

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
               errors++;
               $display("FAIL out_data: got %h expected %h", out_data, mon_exp);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit is_kept(input int a);
      return (a >= 5) && (((a - 5) % 4) == 0);
   endfunction

   task automatic step(input logic e, input logic [7:0] d, input logic c);
      en        = e;
      data_in   = d;
      clear_ovf = c;
      @(posedge clk);
      #1;
      if (e) acc++;
   endtask

   task automatic ramp(input int first, input int last, input bit chk);
      bit k;
      for (int v = first; v <= last; v++) begin
         k = is_kept(acc);
         step(1'b1, 8'(v), 1'b0);
         if (chk) begin
            check("valid_latency", out_valid, k);
            check("count_le1", fifo_count <= 3'd1, 1);
         end
      end
   endtask

   task automatic do_reset();
      en = 1'b0;
      out_ready = 1'b0;
      clear_ovf = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #3;
      reset = 1'b1;
      exp_q.delete();
      acc = 0;
   endtask

   task automatic wait_drain(input string name);
      en = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         step(1'b0, 8'h00, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0);
      check(name, exp_q.size(), 0);
      check("drain_count", fifo_count, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #2;
      check("rst_valid", out_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_data", out_data, 0);

      // T1 streaming with consumer always ready
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(8'h06); exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0E); exp_q.push_back(8'h12);
      ramp(1, 20, 1);
      wait_drain("t1_drain");

      // T2 fill without consumer, then T6 clear vs drop
      do_reset();
      exp_q.push_back(8'h06); exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0E); exp_q.push_back(8'h12);
      ramp(1, 6, 0);   check("t2_count1", fifo_count, 1);
      ramp(7, 10, 0);  check("t2_count2", fifo_count, 2);
      ramp(11, 14, 0); check("t2_count3", fifo_count, 3);
      ramp(15, 18, 0); check("t2_count4", fifo_count, 4);
      check("t2_ovf0", overflow, 0);
      ramp(19, 21, 0); check("t2_ovf_still0", overflow, 0);
      ramp(22, 22, 0);
      check("t2_ovf1", overflow, 1);
      check("t2_count_full", fifo_count, 4);
      ramp(23, 25, 0);
      step(1'b1, 8'd26, 1'b1);
      check("t6_drop_wins", overflow, 1);
      step(1'b0, 8'h00, 1'b1);
      check("t6_cleared", overflow, 0);
      wait_drain("t2_drain");

      // T3 full FIFO with simultaneous pop and push
      do_reset();
      exp_q.push_back(8'h06); exp_q.push_back(8'h0A); exp_q.push_back(8'h0E);
      exp_q.push_back(8'h12); exp_q.push_back(8'h16);
      ramp(1, 21, 0);
      check("t3_full", fifo_count, 4);
      out_ready = 1'b1;
      step(1'b1, 8'h16, 1'b0);
      check("t3_count_stays", fifo_count, 4);
      check("t3_no_ovf", overflow, 0);
      wait_drain("t3_drain");

      // T4 en low every other cycle
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(8'h06); exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0E); exp_q.push_back(8'h12);
      for (int v = 1; v <= 20; v++) begin
         step(1'b1, 8'(v), 1'b0);
         step(1'b0, 8'hFF, 1'b0);
      end
      wait_drain("t4_drain");

      // T5 asynchronous reset with data buffered and overflow set
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(8'h06); exp_q.push_back(8'h0A); exp_q.push_back(8'h0E);
      ramp(1, 15, 1);
      out_ready = 1'b0;
      ramp(16, 34, 0);
      check("t5_pre_count", fifo_count, 4);
      check("t5_pre_ovf", overflow, 1);
      check("t5_three_out", exp_q.size(), 0);
      #2;
      reset = 1'b0;
      #1;
      check("t5_async_valid", out_valid, 0);
      check("t5_async_count", fifo_count, 0);
      check("t5_async_ovf", overflow, 0);
      check("t5_async_data", out_data, 0);
      @(posedge clk);
      #1;
      check("t5_held_count", fifo_count, 0);
      #2;
      reset = 1'b1;
      acc = 0;
      exp_q.delete();
      out_ready = 1'b1;
      exp_q.push_back(8'h06); exp_q.push_back(8'h0A);
      ramp(1, 10, 1);
      wait_drain("t5_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
